// File: rtl/redmule_pkg.sv
// -----------------------------------------------------------------------------
// redmule_pkg
// Shared types and geometry constants for the RedMulE tile-loop scheduler.
//   tile_sched_state_e : scheduler FSM states
//   tile_sched_cfg_t   : per-job iteration counts and leftovers
//   tile_cmd_t         : one tile command (indices, lengths, first/last-k flags)
//   TILE_M/N/K         : full tile sizes derived from the array geometry
// -----------------------------------------------------------------------------
package redmule_pkg;

    localparam int RM_ARRAY_HEIGHT = 32;
    localparam int RM_PIPE_REGS    = 1;
    localparam int RM_ITER_W       = 16;
    localparam int RM_LFT_W        = 8;

    // Full tile sizes: M rows, N columns, K depth.
    localparam int TILE_M = RM_ARRAY_HEIGHT * RM_PIPE_REGS;
    localparam int TILE_N = (RM_PIPE_REGS + 1) * RM_ARRAY_HEIGHT;
    localparam int TILE_K = RM_ARRAY_HEIGHT;

    // Length fields must hold the full size itself, hence the +1.
    localparam int M_LEN_W = $clog2(TILE_M) + 1;
    localparam int N_LEN_W = $clog2(TILE_N) + 1;
    localparam int K_LEN_W = $clog2(TILE_K) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } tile_sched_state_e;

    typedef struct packed {
        logic [RM_ITER_W-1:0] m_iters;
        logic [RM_ITER_W-1:0] n_iters;
        logic [RM_ITER_W-1:0] k_iters;
        logic [RM_LFT_W-1:0]  m_lftovr;
        logic [RM_LFT_W-1:0]  n_lftovr;
        logic [RM_LFT_W-1:0]  k_lftovr;
    } tile_sched_cfg_t;

    typedef struct packed {
        logic [RM_ITER_W-1:0] m_idx;
        logic [RM_ITER_W-1:0] n_idx;
        logic [RM_ITER_W-1:0] k_idx;
        logic [M_LEN_W-1:0]   m_len;
        logic [N_LEN_W-1:0]   n_len;
        logic [K_LEN_W-1:0]   k_len;
        logic                 first_k;
        logic                 last_k;
    } tile_cmd_t;

    // A job with an empty dimension has no tiles and is reported as an error.
    function automatic logic cfg_has_zero(input tile_sched_cfg_t cfg);
        return (cfg.m_iters == '0) || (cfg.n_iters == '0) || (cfg.k_iters == '0);
    endfunction

endpackage

// File: rtl/redmule_wrap_cnt.sv
// -----------------------------------------------------------------------------
// redmule_wrap_cnt
// Wrapping up-counter used as one level of the tile-loop nest.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clear_i      : synchronous clear to 0 (wins over en_i)
//   en_i         : advance by one; wraps to 0 after reaching max_i
//   max_i        : terminal count (iterations - 1)
//   cnt_o        : current count
//   wrap_o       : count is at its terminal value
//   carry_o      : advancing this cycle will wrap (en_i & wrap_o); feeds the
//                  enable of the next outer counter
// -----------------------------------------------------------------------------
module redmule_wrap_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         en_i,
    input  logic [W-1:0] max_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o,
    output logic         carry_o
);

    logic [W-1:0] cnt_reg;

    assign cnt_o   = cnt_reg;
    assign wrap_o  = (cnt_reg == max_i);
    assign carry_o = en_i & wrap_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
        end else if (clear_i) begin
            cnt_reg <= '0;
        end else if (en_i) begin
            cnt_reg <= wrap_o ? '0 : cnt_reg + W'(1);
        end
    end

endmodule

// File: rtl/redmule_tile_sched.sv
// -----------------------------------------------------------------------------
// redmule_tile_sched
// Walks the (m, n, k) tile space of one RedMulE job, K innermost, issuing one
// tile command per tile and one Z-store request per completed output block.
// Tile issue is throttled so that at most MAX_PEND stores are outstanding.
//
// Ports
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   clear_i               : synchronous soft clear (drops pending stores)
//   start_i               : job start, honoured only in IDLE
//   {m,n,k}_iters_i       : blocks per dimension (including a partial block)
//   {m,n,k}_lftovr_i      : size of the last block, 0 = full
//   tile_valid_o/ready_i  : tile command handshake
//   tile_{m,n,k}_o        : tile indices
//   tile_{m,n,k}_len_o    : tile extents (0 whenever tile_valid_o is low)
//   tile_first_k_o        : first K step, Y preload needed
//   tile_last_k_o         : last K step, a store follows
//   store_valid_o/ready_i : Z-store request handshake
//   store_cnt_o           : accepted stores in this job (saturating)
//   busy_o                : job in progress (any state but IDLE)
//   done_o                : one-cycle end-of-job pulse
//   cfg_err_o             : with done_o when an iteration count was zero
//
// Every output is a register or a function of registers only, so the ready
// inputs never reach an output combinationally.
// -----------------------------------------------------------------------------
module redmule_tile_sched
    import redmule_pkg::*;
#(
    parameter int ARRAY_HEIGHT = RM_ARRAY_HEIGHT,
    parameter int PIPE_REGS    = RM_PIPE_REGS,
    parameter int ARRAY_WIDTH  = ARRAY_HEIGHT * PIPE_REGS,
    parameter int TILE         = (PIPE_REGS + 1) * ARRAY_HEIGHT,
    parameter int ITER_W       = RM_ITER_W,
    parameter int LFT_W        = RM_LFT_W,
    parameter int MAX_PEND     = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             clear_i,
    input  logic                             start_i,
    input  logic [ITER_W-1:0]                m_iters_i,
    input  logic [ITER_W-1:0]                n_iters_i,
    input  logic [ITER_W-1:0]                k_iters_i,
    input  logic [LFT_W-1:0]                 m_lftovr_i,
    input  logic [LFT_W-1:0]                 n_lftovr_i,
    input  logic [LFT_W-1:0]                 k_lftovr_i,
    output logic                             tile_valid_o,
    input  logic                             tile_ready_i,
    output logic [ITER_W-1:0]                tile_m_o,
    output logic [ITER_W-1:0]                tile_n_o,
    output logic [ITER_W-1:0]                tile_k_o,
    output logic [$clog2(ARRAY_WIDTH):0]     tile_m_len_o,
    output logic [$clog2(TILE):0]            tile_n_len_o,
    output logic [$clog2(ARRAY_HEIGHT):0]    tile_k_len_o,
    output logic                             tile_first_k_o,
    output logic                             tile_last_k_o,
    output logic                             store_valid_o,
    input  logic                             store_ready_i,
    output logic [ITER_W-1:0]                store_cnt_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             cfg_err_o
);

    localparam int ML_W   = $clog2(ARRAY_WIDTH) + 1;
    localparam int NL_W   = $clog2(TILE) + 1;
    localparam int KL_W   = $clog2(ARRAY_HEIGHT) + 1;
    localparam int PEND_W = $clog2(MAX_PEND + 1);

    // Loop levels, innermost first.
    localparam int LVL_K = 0;
    localparam int LVL_N = 1;
    localparam int LVL_M = 2;

    tile_sched_state_e state_reg;
    tile_sched_cfg_t   cfg_reg;
    tile_sched_cfg_t   cfg_in;
    logic [PEND_W-1:0] pend_reg;
    logic [PEND_W-1:0] pend_next;
    logic [ITER_W-1:0] store_cnt_reg;
    logic              tile_valid_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              cfg_err_reg;

    logic              tile_hs;
    logic              store_hs;
    logic              store_push;
    logic              last_tile;
    logic              cnt_clear;

    logic [ITER_W-1:0] cnt_val [3];
    logic [ITER_W-1:0] cnt_max [3];
    logic [2:0]        cnt_en;
    logic [2:0]        cnt_wrap;
    logic [2:0]        cnt_carry;

    tile_cmd_t         cmd;

    assign cfg_in.m_iters  = m_iters_i;
    assign cfg_in.n_iters  = n_iters_i;
    assign cfg_in.k_iters  = k_iters_i;
    assign cfg_in.m_lftovr = m_lftovr_i;
    assign cfg_in.n_lftovr = n_lftovr_i;
    assign cfg_in.k_lftovr = k_lftovr_i;

    assign tile_hs    = tile_valid_reg & tile_ready_i;
    assign store_hs   = (pend_reg != '0) & store_ready_i;
    // A handshake on the last K step closes an output block.
    assign store_push = tile_hs & cnt_wrap[LVL_K];
    // Carry out of the outermost level only happens on the final tile.
    assign last_tile  = cnt_carry[LVL_M];
    // Starting a job rewinds the loop nest as well as a soft clear does.
    assign cnt_clear  = clear_i | ((state_reg == IDLE) & start_i);

    assign cnt_max[LVL_K] = cfg_reg.k_iters - ITER_W'(1);
    assign cnt_max[LVL_N] = cfg_reg.n_iters - ITER_W'(1);
    assign cnt_max[LVL_M] = cfg_reg.m_iters - ITER_W'(1);

    // ---------------------------------------------------------------------
    // Loop nest: k advances on every tile handshake, each outer level on the
    // carry of the level inside it.
    // ---------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_loop
            if (gi == 0) begin : g_inner
                assign cnt_en[gi] = tile_hs;
            end else begin : g_outer
                assign cnt_en[gi] = cnt_carry[gi-1];
            end

            redmule_wrap_cnt #(
                .W (ITER_W)
            ) u_cnt (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .clear_i (cnt_clear),
                .en_i    (cnt_en[gi]),
                .max_i   (cnt_max[gi]),
                .cnt_o   (cnt_val[gi]),
                .wrap_o  (cnt_wrap[gi]),
                .carry_o (cnt_carry[gi])
            );
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Tile extents: the last block of a dimension uses its leftover if one
    // was given. Leftovers are zero-extended before narrowing so any LFT_W
    // works against any length width.
    // ---------------------------------------------------------------------
    logic [LFT_W+ML_W-1:0] m_lft_ext;
    logic [LFT_W+NL_W-1:0] n_lft_ext;
    logic [LFT_W+KL_W-1:0] k_lft_ext;
    logic                  m_partial;
    logic                  n_partial;
    logic                  k_partial;

    assign m_lft_ext = {{ML_W{1'b0}}, cfg_reg.m_lftovr};
    assign n_lft_ext = {{NL_W{1'b0}}, cfg_reg.n_lftovr};
    assign k_lft_ext = {{KL_W{1'b0}}, cfg_reg.k_lftovr};

    assign m_partial = cnt_wrap[LVL_M] & (cfg_reg.m_lftovr != '0);
    assign n_partial = cnt_wrap[LVL_N] & (cfg_reg.n_lftovr != '0);
    assign k_partial = cnt_wrap[LVL_K] & (cfg_reg.k_lftovr != '0);

    always_comb begin
        cmd         = '0;
        cmd.m_idx   = cnt_val[LVL_M];
        cmd.n_idx   = cnt_val[LVL_N];
        cmd.k_idx   = cnt_val[LVL_K];
        cmd.m_len   = m_partial ? m_lft_ext[ML_W-1:0] : ML_W'(ARRAY_WIDTH);
        cmd.n_len   = n_partial ? n_lft_ext[NL_W-1:0] : NL_W'(TILE);
        cmd.k_len   = k_partial ? k_lft_ext[KL_W-1:0] : KL_W'(ARRAY_HEIGHT);
        cmd.first_k = (cnt_val[LVL_K] == '0);
        cmd.last_k  = cnt_wrap[LVL_K];
    end

    // Command fields are forced to 0 whenever no command is offered. The
    // counters only move on a handshake, so a stalled command stays stable.
    assign tile_valid_o   = tile_valid_reg;
    assign tile_m_o       = tile_valid_reg ? cmd.m_idx   : '0;
    assign tile_n_o       = tile_valid_reg ? cmd.n_idx   : '0;
    assign tile_k_o       = tile_valid_reg ? cmd.k_idx   : '0;
    assign tile_m_len_o   = tile_valid_reg ? cmd.m_len   : '0;
    assign tile_n_len_o   = tile_valid_reg ? cmd.n_len   : '0;
    assign tile_k_len_o   = tile_valid_reg ? cmd.k_len   : '0;
    assign tile_first_k_o = tile_valid_reg & cmd.first_k;
    assign tile_last_k_o  = tile_valid_reg & cmd.last_k;

    assign store_valid_o  = (pend_reg != '0);
    assign store_cnt_o    = store_cnt_reg;
    assign busy_o         = busy_reg;
    assign done_o         = done_reg;
    assign cfg_err_o      = cfg_err_reg;

    // Outstanding stores: a push and a pop in the same cycle cancel out.
    always_comb begin
        pend_next = pend_reg;
        if (store_push && !store_hs) begin
            pend_next = pend_reg + PEND_W'(1);
        end else if (!store_push && store_hs) begin
            pend_next = pend_reg - PEND_W'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Control FSM with registered outputs. tile_valid is computed from the
    // next pending count so issue resumes the cycle after a store drains a
    // slot, and never drops while a command is offered and not taken
    // (pending only grows through a handshake).
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            cfg_reg        <= '0;
            pend_reg       <= '0;
            store_cnt_reg  <= '0;
            tile_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            cfg_err_reg    <= 1'b0;
        end else if (clear_i) begin
            state_reg      <= IDLE;
            cfg_reg        <= '0;
            pend_reg       <= '0;
            store_cnt_reg  <= '0;
            tile_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            cfg_err_reg    <= 1'b0;
        end else begin
            pend_reg    <= pend_next;
            done_reg    <= 1'b0;
            cfg_err_reg <= 1'b0;
            if (store_hs && (store_cnt_reg != '1)) begin
                store_cnt_reg <= store_cnt_reg + ITER_W'(1);
            end

            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        cfg_reg       <= cfg_in;
                        store_cnt_reg <= '0;
                        busy_reg      <= 1'b1;
                        if (cfg_has_zero(cfg_in)) begin
                            state_reg   <= DONE;
                            done_reg    <= 1'b1;
                            cfg_err_reg <= 1'b1;
                        end else begin
                            state_reg      <= ISSUE;
                            tile_valid_reg <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (last_tile) begin
                        state_reg      <= DRAIN;
                        tile_valid_reg <= 1'b0;
                    end else begin
                        tile_valid_reg <= (pend_next < PEND_W'(MAX_PEND));
                    end
                end
                DRAIN: begin
                    if (pend_reg == '0) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_redmule_tile_sched.sv
// -----------------------------------------------------------------------------
// tb_redmule_tile_sched
// Directed bench for the tile-loop scheduler. Each job pushes its expected
// tile sequence into a scoreboard queue; every tile handshake pops and
// compares one entry. Inputs change and outputs are sampled on the falling
// clock edge.
// -----------------------------------------------------------------------------
module tb_redmule_tile_sched;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clear_i;
    logic        start_i;
    logic [15:0] m_iters_i, n_iters_i, k_iters_i;
    logic [7:0]  m_lftovr_i, n_lftovr_i, k_lftovr_i;
    logic        tile_valid_o;
    logic        tile_ready_i;
    logic [15:0] tile_m_o, tile_n_o, tile_k_o;
    logic [5:0]  tile_m_len_o;
    logic [6:0]  tile_n_len_o;
    logic [5:0]  tile_k_len_o;
    logic        tile_first_k_o, tile_last_k_o;
    logic        store_valid_o;
    logic        store_ready_i;
    logic [15:0] store_cnt_o;
    logic        busy_o, done_o, cfg_err_o;

    int checks = 0;
    int errors = 0;

    logic [68:0] exp_q [$];
    logic [69:0] cur_cmd;

    always #5 clk_i = ~clk_i;

    redmule_tile_sched dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .clear_i        (clear_i),
        .start_i        (start_i),
        .m_iters_i      (m_iters_i),
        .n_iters_i      (n_iters_i),
        .k_iters_i      (k_iters_i),
        .m_lftovr_i     (m_lftovr_i),
        .n_lftovr_i     (n_lftovr_i),
        .k_lftovr_i     (k_lftovr_i),
        .tile_valid_o   (tile_valid_o),
        .tile_ready_i   (tile_ready_i),
        .tile_m_o       (tile_m_o),
        .tile_n_o       (tile_n_o),
        .tile_k_o       (tile_k_o),
        .tile_m_len_o   (tile_m_len_o),
        .tile_n_len_o   (tile_n_len_o),
        .tile_k_len_o   (tile_k_len_o),
        .tile_first_k_o (tile_first_k_o),
        .tile_last_k_o  (tile_last_k_o),
        .store_valid_o  (store_valid_o),
        .store_ready_i  (store_ready_i),
        .store_cnt_o    (store_cnt_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .cfg_err_o      (cfg_err_o)
    );

    assign cur_cmd = {tile_valid_o, tile_m_o, tile_n_o, tile_k_o, tile_m_len_o,
                      tile_n_len_o, tile_k_len_o, tile_first_k_o, tile_last_k_o};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected tile stream for one job, in K-innermost order.
    task automatic push_expected(input int m, input int n, input int k,
                                 input int ml, input int nl, input int kl);
        logic [5:0] mlen;
        logic [6:0] nlen;
        logic [5:0] klen;
        for (int mi = 0; mi < m; mi++)
            for (int ni = 0; ni < n; ni++)
                for (int ki = 0; ki < k; ki++) begin
                    mlen = (mi == m - 1 && ml != 0) ? 6'(ml) : 6'd32;
                    nlen = (ni == n - 1 && nl != 0) ? 7'(nl) : 7'd64;
                    klen = (ki == k - 1 && kl != 0) ? 6'(kl) : 6'd32;
                    exp_q.push_back({16'(mi), 16'(ni), 16'(ki), mlen, nlen, klen,
                                     (ki == 0), (ki == k - 1)});
                end
    endtask

    task automatic pulse_start(input int m, input int n, input int k,
                               input int ml, input int nl, input int kl);
        m_iters_i  = 16'(m);
        n_iters_i  = 16'(n);
        k_iters_i  = 16'(k);
        m_lftovr_i = 8'(ml);
        n_lftovr_i = 8'(nl);
        k_lftovr_i = 8'(kl);
        start_i    = 1'b1;
        @(negedge clk_i);
        start_i    = 1'b0;
    endtask

    // Runs one complete job. rand_rdy toggles tile_ready_i randomly;
    // store_hold keeps store_ready_i low for that many cycles and then checks
    // that issue has throttled at two outstanding stores.
    task automatic run_job(input string name, input int m, input int n, input int k,
                           input int ml, input int nl, input int kl,
                           input bit rand_rdy, input int store_hold, output int done_cyc);
        int          issued = 0;
        int          stores = 0;
        bit          fin = 1'b0;
        bit          prev_stall = 1'b0;
        logic [69:0] saved = '0;
        logic [68:0] exp_t;
        done_cyc = -1;
        exp_q.delete();
        push_expected(m, n, k, ml, nl, kl);
        tile_ready_i  = 1'b1;
        store_ready_i = (store_hold == 0);
        pulse_start(m, n, k, ml, nl, kl);
        check({name, "_busy_t1"}, busy_o, 1'b1);
        check({name, "_valid_t1"}, tile_valid_o, 1'b1);
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            if (store_hold > 0 && cyc == store_hold) begin
                check({name, "_throttle_valid"}, tile_valid_o, 1'b0);
                check({name, "_throttle_issued"}, issued, 2);
                check({name, "_throttle_store_valid"}, store_valid_o, 1'b1);
            end
            store_ready_i = (cyc >= store_hold);
            tile_ready_i  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (prev_stall) check({name, "_stall_stable"}, cur_cmd, saved);
            if (done_o) begin
                fin = 1'b1;
                done_cyc = cyc;
            end else begin
                if (tile_valid_o && tile_ready_i) begin
                    if (exp_q.size() == 0) begin
                        check({name, "_extra_tile"}, cur_cmd[68:0], '0 - 1);
                    end else begin
                        exp_t = exp_q.pop_front();
                        check($sformatf("%s_tile%0d", name, issued), cur_cmd[68:0], exp_t);
                    end
                    issued++;
                end
                if (store_valid_o && store_ready_i) stores++;
                prev_stall = tile_valid_o && !tile_ready_i;
                saved = cur_cmd;
                @(negedge clk_i);
            end
        end
        check({name, "_done_seen"}, fin, 1'b1);
        check({name, "_tiles_total"}, issued, m * n * k);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_stores_total"}, stores, m * n);
        check({name, "_store_cnt"}, store_cnt_o, 16'(m * n));
        check({name, "_cfg_err"}, cfg_err_o, 1'b0);
        $display("job %s: %0d tiles, %0d stores, done after %0d cycles", name, issued, stores, done_cyc);
        @(negedge clk_i);
        check({name, "_busy_after_done"}, busy_o, 1'b0);
        check({name, "_done_single"}, done_o, 1'b0);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_busy"}, busy_o, 1'b0);
        check({name, "_cmd"}, cur_cmd, '0);
        check({name, "_store_valid"}, store_valid_o, 1'b0);
        check({name, "_store_cnt"}, store_cnt_o, '0);
        check({name, "_done"}, done_o, 1'b0);
        check({name, "_cfg_err"}, cfg_err_o, 1'b0);
    endtask

    task automatic expect_no_done(input string name);
        int seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done_o) seen++;
            @(negedge clk_i);
        end
        check({name, "_no_done"}, seen, 0);
    endtask

    initial begin
        int lat;
        rst_i = 1'b1;
        clear_i = 1'b0;
        start_i = 1'b0;
        tile_ready_i = 1'b0;
        store_ready_i = 1'b0;
        m_iters_i = '0; n_iters_i = '0; k_iters_i = '0;
        m_lftovr_i = '0; n_lftovr_i = '0; k_lftovr_i = '0;
        repeat (3) @(negedge clk_i);
        check_idle_outputs("reset");
        rst_i = 1'b0;
        @(negedge clk_i);

        // Single tile, full lengths.
        run_job("single", 1, 1, 1, 0, 0, 0, 1'b0, 0, lat);
        check("single_done_latency", (lat >= 2 && lat <= 4), 1'b1);

        // K leftover on the last K step.
        run_job("kleft", 2, 1, 3, 0, 0, 5, 1'b0, 0, lat);

        // Stores blocked: issue throttles at two pending stores.
        run_job("throttle", 1, 3, 1, 0, 0, 0, 1'b0, 8, lat);

        // Random tile_ready with M and N leftovers.
        run_job("random", 2, 3, 2, 7, 10, 0, 1'b1, 0, lat);

        // Zero iteration count: immediate done with error.
        tile_ready_i = 1'b1;
        store_ready_i = 1'b1;
        pulse_start(2, 0, 2, 0, 0, 0);
        check("cfgerr_done", done_o, 1'b1);
        check("cfgerr_flag", cfg_err_o, 1'b1);
        check("cfgerr_no_tile", tile_valid_o, 1'b0);
        @(negedge clk_i);
        check("cfgerr_done_single", done_o, 1'b0);
        check("cfgerr_busy_after", busy_o, 1'b0);

        // Soft clear with one store pending.
        tile_ready_i = 1'b1;
        store_ready_i = 1'b0;
        pulse_start(2, 2, 1, 0, 0, 0);
        @(negedge clk_i);
        check("clear_pend_store_valid", store_valid_o, 1'b1);
        tile_ready_i = 1'b0;
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        check_idle_outputs("clear");
        expect_no_done("clear");
        run_job("after_clear", 1, 2, 2, 0, 0, 9, 1'b0, 0, lat);

        // Asynchronous reset mid-job.
        tile_ready_i = 1'b1;
        store_ready_i = 1'b0;
        pulse_start(2, 1, 3, 0, 0, 5);
        repeat (2) @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1 check_idle_outputs("async_rst");
        @(negedge clk_i);
        rst_i = 1'b0;
        expect_no_done("async_rst");
        run_job("after_rst", 2, 1, 3, 0, 0, 5, 1'b0, 0, lat);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
